// File: rtl/alu_rs_scheduler_if.sv
// rtl/alu_rs_scheduler_if.sv - issue, CDB and status signals of the add/sub reservation station
interface alu_rs_if #(
  parameter int RS_NUM = 3,
  parameter int TAG_W  = 4
);
  logic              issueValid;
  logic              issueReady;
  logic              issueOp;
  logic [TAG_W-1:0]  issueQj;
  logic [TAG_W-1:0]  issueQk;
  logic [31:0]       issueVj;
  logic [31:0]       issueVk;
  logic [TAG_W-1:0]  issueTag;
  logic              cdbValid;
  logic [TAG_W-1:0]  cdbTag;
  logic [31:0]       cdbData;
  logic              cdbReq;
  logic [TAG_W-1:0]  cdbReqTag;
  logic [31:0]       cdbReqData;
  logic              cdbGrant;
  logic [RS_NUM-1:0] busy;

  modport master (
    output issueValid, issueOp, issueQj, issueQk, issueVj, issueVk,
    output cdbValid, cdbTag, cdbData, cdbGrant,
    input  issueReady, issueTag, cdbReq, cdbReqTag, cdbReqData, busy
  );

  modport slave (
    input  issueValid, issueOp, issueQj, issueQk, issueVj, issueVk,
    input  cdbValid, cdbTag, cdbData, cdbGrant,
    output issueReady, issueTag, cdbReq, cdbReqTag, cdbReqData, busy
  );
endinterface

// File: rtl/alu_rs_scheduler.sv
// rtl/alu_rs_scheduler.sv - reservation-station scheduler feeding the shared add/sub ALU
module alu_rs_scheduler #(
  parameter int RS_NUM   = 3,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 1
) (
  input  logic     clk,
  input  logic     nRST,
  alu_rs_if.slave  rs
);
  localparam int IDX_W = (RS_NUM > 1) ? $clog2(RS_NUM) : 1;

  typedef enum logic [1:0] {sIdle, sInv, sAdd, sMAdd} state_t;

  state_t            state;
  logic [RS_NUM-1:0] busy_q, disp_q, op_q;
  logic [TAG_W-1:0]  qj_q [RS_NUM];
  logic [TAG_W-1:0]  qk_q [RS_NUM];
  logic [31:0]       vj_q [RS_NUM];
  logic [31:0]       vk_q [RS_NUM];
  logic [IDX_W-1:0]  rr_ptr, exec_idx;
  logic [31:0]       a_q, b_q;
  logic [TAG_W-1:0]  tag_q;
  logic              req_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [31:0]       req_data_q;

  logic [RS_NUM-1:0] ready;
  logic              free_found, sel_found;
  logic [IDX_W-1:0]  free_idx, sel_idx;
  logic [TAG_W-1:0]  sel_tag;
  logic              grant, do_dispatch;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_NUM - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_NUM; i++) begin
      ready[i] = busy_q[i] & ~disp_q[i] & (qj_q[i] == '0) & (qk_q[i] == '0);
    end
  end

  // Round-robin: the search begins just past the last dispatched entry.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= RS_NUM; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % RS_NUM;
      if (!sel_found && ready[j]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(j);
      end
    end
  end

  assign sel_tag     = TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
  assign grant       = ((state == sAdd) || (state == sMAdd)) && req_q && rs.cdbGrant;
  assign do_dispatch = sel_found && ((state == sIdle) || grant);

  assign rs.issueReady = free_found;
  assign rs.issueTag   = free_found ? (TAG_W'(TAG_BASE) + TAG_W'(free_idx)) : '0;
  assign rs.cdbReq     = req_q;
  assign rs.cdbReqTag  = req_tag_q;
  assign rs.cdbReqData = req_data_q;
  assign rs.busy       = busy_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= sIdle;
      busy_q     <= '0;
      disp_q     <= '0;
      op_q       <= '0;
      rr_ptr     <= '0;
      exec_idx   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      req_q      <= 1'b0;
      req_tag_q  <= '0;
      req_data_q <= '0;
      for (int i = 0; i < RS_NUM; i++) begin
        qj_q[i] <= '0;
        qk_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_NUM; i++) begin
        if (busy_q[i] && rs.cdbValid && (qj_q[i] != '0) && (qj_q[i] == rs.cdbTag)) begin
          qj_q[i] <= '0;
          vj_q[i] <= rs.cdbData;
        end
        if (busy_q[i] && rs.cdbValid && (qk_q[i] != '0) && (qk_q[i] == rs.cdbTag)) begin
          qk_q[i] <= '0;
          vk_q[i] <= rs.cdbData;
        end
      end

      // Free set is the registered one, so an entry freed by this edge's grant is not reused yet.
      if (rs.issueValid && free_found) begin
        busy_q[free_idx] <= 1'b1;
        disp_q[free_idx] <= 1'b0;
        op_q[free_idx]   <= rs.issueOp;
        if (rs.cdbValid && (rs.issueQj != '0) && (rs.issueQj == rs.cdbTag)) begin
          qj_q[free_idx] <= '0;
          vj_q[free_idx] <= rs.cdbData;
        end else begin
          qj_q[free_idx] <= rs.issueQj;
          vj_q[free_idx] <= rs.issueVj;
        end
        if (rs.cdbValid && (rs.issueQk != '0) && (rs.issueQk == rs.cdbTag)) begin
          qk_q[free_idx] <= '0;
          vk_q[free_idx] <= rs.cdbData;
        end else begin
          qk_q[free_idx] <= rs.issueQk;
          vk_q[free_idx] <= rs.issueVk;
        end
      end

      if (grant) begin
        busy_q[exec_idx] <= 1'b0;
        disp_q[exec_idx] <= 1'b0;
      end

      if (do_dispatch) begin
        disp_q[sel_idx] <= 1'b1;
        rr_ptr          <= sel_idx;
        exec_idx        <= sel_idx;
        a_q             <= vj_q[sel_idx];
        b_q             <= vk_q[sel_idx];
        tag_q           <= sel_tag;
        if (op_q[sel_idx]) begin
          state <= sInv;
          req_q <= 1'b0;
        end else begin
          state <= sAdd;
          // An add following a grant keeps the request up so results stream one per cycle.
          if (grant) begin
            req_q      <= 1'b1;
            req_tag_q  <= sel_tag;
            req_data_q <= vj_q[sel_idx] + vk_q[sel_idx];
          end else begin
            req_q <= 1'b0;
          end
        end
      end else begin
        case (state)
          sInv: begin
            b_q   <= ~b_q;
            state <= sMAdd;
          end
          sAdd, sMAdd: begin
            if (!req_q) begin
              req_q      <= 1'b1;
              req_tag_q  <= tag_q;
              req_data_q <= a_q + b_q + {31'b0, (state == sMAdd)};
            end else if (grant) begin
              req_q <= 1'b0;
              state <= sIdle;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/alu_rs_scheduler.md
# alu_rs_scheduler

Reservation-station scheduler for the shared add/sub ALU in the Tomasulo core. It holds up to RS_NUM add/sub instructions and wakes their operands by snooping the common data bus (CDB). It dispatches one ready instruction at a time into its internal 32-bit add/sub datapath, sequencing add in one stage and subtract in two. It then requests the CDB and frees the entry when the arbiter accepts the result.

## Interface
- RS_NUM, 3, number of reservation-station entries (2..8)
- TAG_W, 4, tag width; tag 0 means "value present, no producer"
- TAG_BASE, 1, tag of entry 0; entry i owns tag TAG_BASE+i

- clk  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- issueValid  in  1  issue unit offers an instruction
- issueReady  out  1  at least one entry free (registered busy state)
- issueOp  in  1  0 = add, 1 = sub (A − B)
- issueQj / issueQk  in  TAG_W  producer tags of A / B (0 = value in issueVj/issueVk)
- issueVj / issueVk  in  32  operand values
- issueTag  out  TAG_W  tag given to the offered instruction: TAG_BASE + lowest free index; 0 when full
- cdbValid  in  1  CDB broadcast valid
- cdbTag  in  TAG_W  CDB tag
- cdbData  in  32  CDB value
- cdbReq  out  1  result waiting for the CDB
- cdbReqTag  out  TAG_W  tag of the result
- cdbReqData  out  32  result value
- cdbGrant  in  1  CDB arbiter accepted the result this cycle
- busy  out  RS_NUM  per-entry occupied flags

## Operation
- Entry fields: busy, dispatched, op, Qj, Vj, Qk, Vk.
- Issue: on a clk edge with issueValid && issueReady, lowest free entry gets busy=1, dispatched=0, op and operands.
- Same-cycle bypass: if cdbValid and issueQx == cdbTag (nonzero), store Vx=cdbData, Qx=0.
- Wakeup: every edge, each busy entry with nonzero Qx == cdbTag && cdbValid loads Vx=cdbData, Qx=0.
- Ready = busy && !dispatched && Qj==0 && Qk==0. Registered fields only; an operand woken this edge is eligible next cycle.
- Selection: round-robin. Search starts at index rrPtr+1 mod RS_NUM, where rrPtr is the last dispatched index (reset 0, so the first search starts at 1). First ready entry wins.
- FSM states:
  - sIdle: if an entry is ready, dispatch it. Latch A=Vj, B=Vk, tag, mark dispatched. Go to sAdd (add) or sInv (sub).
  - sInv: B <= ~B; go to sMAdd.
  - sAdd: cdbReq=1, cdbReqData = A+B.
  - sMAdd: cdbReq=1, cdbReqData = A+B+1, i.e. A − B mod 2^32.
  - sAdd/sMAdd on cdbGrant: clear busy and dispatched of the executing entry. If another entry is ready, dispatch it at the same edge (back-to-back). Otherwise go to sIdle.
  - sAdd/sMAdd without cdbGrant: hold state, cdbReq, cdbReqTag and cdbReqData unchanged.
- Arithmetic: 32-bit modular; carry and overflow discarded.
- Broadcast loopback: the block's own result returns on cdbTag/cdbData and wakes dependent entries normally; the freed entry ignores it.
- A Q tag naming a free entry is a caller error and is not checked.

## Timing
- Reset (async, immediate): all busy/dispatched = 0, state sIdle, rrPtr = 0, A = B = 0.
  - Outputs: cdbReq = 0, cdbReqTag = 0, cdbReqData = 0, busy = 0, issueReady = 1, issueTag = TAG_BASE.
- Reset mid-operation discards all entries and any pending result; no CDB request survives.
- Latency, operands ready at issue edge n:
  - add: dispatch at edge n+1, cdbReq high from edge n+2.
  - sub: dispatch at n+1, sInv at n+2, cdbReq high from edge n+3.
  - The grant edge ends the request.
- Back-to-back adds with grant on the first request cycle: one result per cycle.
- Freed entry is re-issuable from the cycle after the grant edge; issueReady does not see same-edge frees.
- Full: issueReady = 0, issueTag = 0; issueValid is ignored.
- Simultaneous issue + grant: issue takes the pre-grant free set.
- Simultaneous wakeup + selection: selection uses pre-edge values.

## Test plan
- Reset and add:
  - Assert nRST=0 mid-request → cdbReq=0 and busy=0 immediately.
  - Release reset, issue add Vj=5, Vk=7, Q=0 → issueTag=1; cdbReq at edge n+2 with tag 1, data 12.
  - Hold cdbGrant=0 3 cycles → outputs stable; grant → busy[0]=0.
- Subtract wrap: issue sub 3 − 5 → cdbReqData=32'hFFFFFFFE, first cdbReq one cycle later than add.
- Wakeup and bypass:
  - Issue add Qj=2, Vk=1 → entry waits.
  - CDB tag 2, data 100 → result 101 two cycles after the broadcast.
  - Issue with Qk=3 while cdbValid, tag 3 on the same edge → captured, no stall.
- Full and round-robin:
  - Fill 3 entries, all operands ready → issueReady=0, issueTag=0.
  - Grant every cycle → results in tag order 1,2,3 back-to-back, then sIdle.
- Issue + grant same edge when full → issue not accepted; accepted on the next cycle into the freed entry.
